// File: rtl/battle_pkg.sv
// rtl/battle_pkg.sv - shared field geometry and tile types for the battle field blocks
// Purpose: tile geometry constants, bullet direction encoding and the tile coordinate struct.
// Ports: none (package).
package battle_pkg;

    localparam int BLOCK_SIZE  = 32;
    localparam int COLS        = 17;
    localparam int ROWS        = 14;
    localparam int BLOCK_SHIFT = $clog2(BLOCK_SIZE);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef struct packed {
        logic [4:0] col;
        logic [3:0] row;
    } tile_coord_t;

endpackage

// File: rtl/pixel_to_tile.sv
// rtl/pixel_to_tile.sv - maps a pixel position to a field tile coordinate
// Purpose: combinational bounds check of a pixel against the field and tile index extraction.
// Ports:
//   p_x, p_y                 pixel position
//   top_left_x, top_left_y   field top-left corner
//   in_field                 1 when the pixel lies inside the field
//   tile                     tile column/row (meaningful only when in_field = 1)
module pixel_to_tile
    import battle_pkg::*;
(
    input  logic [10:0]  p_x,
    input  logic [10:0]  p_y,
    input  logic [10:0]  top_left_x,
    input  logic [10:0]  top_left_y,
    output logic         in_field,
    output tile_coord_t  tile
);

    localparam logic [11:0] FIELD_W = 12'(COLS * BLOCK_SIZE);
    localparam logic [11:0] FIELD_H = 12'(ROWS * BLOCK_SIZE);

    logic [10:0] off_x;
    logic [10:0] off_y;
    logic        in_x;
    logic        in_y;

    always_comb begin
        off_x = p_x - top_left_x;
        off_y = p_y - top_left_y;
        // 12-bit compares so that topLeft + field size cannot wrap around.
        in_x = ({1'b0, p_x} >= {1'b0, top_left_x}) &&
               ({1'b0, p_x} <  ({1'b0, top_left_x} + FIELD_W));
        in_y = ({1'b0, p_y} >= {1'b0, top_left_y}) &&
               ({1'b0, p_y} <  ({1'b0, top_left_y} + FIELD_H));
        in_field = in_x && in_y;
        tile.col = 5'(off_x >> BLOCK_SHIFT);
        tile.row = 4'(off_y >> BLOCK_SHIFT);
    end

endmodule

// File: rtl/brick_hit_reporter.sv
// rtl/brick_hit_reporter.sv - per-frame bullet vs brick probe and collision reporter
// Purpose: once per frame probes two pixels just beyond the bullet's leading edge, reports each
//          occupied tile as a collision request and tells the bullet to die on a hit or field exit.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   startOfFrame, bulletActive   pass trigger and bullet presence
//   bulletX, bulletY, bulletDir  bullet top-left position and travel direction
//   topLeftX, topLeftY           field origin
//   matrix                       brick occupancy [row][col]
//   collision                    hit request, held HOLD_CYCLES per tile
//   brickCollisionX/Y            tile column/row of the current request
//   bulletKill                   one-cycle bullet removal pulse
//   hitCount                     saturating count of reported tiles
module brick_hit_reporter
    import battle_pkg::*;
#(
    parameter int BULLET_SIZE = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       startOfFrame,
    input  logic                       bulletActive,
    input  logic [10:0]                bulletX,
    input  logic [10:0]                bulletY,
    input  logic [1:0]                 bulletDir,
    input  logic [10:0]                topLeftX,
    input  logic [10:0]                topLeftY,
    input  logic [ROWS-1:0][COLS-1:0]  matrix,
    output logic                       collision,
    output logic [4:0]                 brickCollisionX,
    output logic [3:0]                 brickCollisionY,
    output logic                       bulletKill,
    output logic [7:0]                 hitCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_PROBE0,
        S_PROBE1,
        S_ASSERT,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam int          HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [10:0] S_FULL = 11'(BULLET_SIZE);
    localparam logic [10:0] S_LAST = 11'(BULLET_SIZE - 1);

    state_t       state, state_next;
    logic         kill_next;

    logic [10:0]  x_q, y_q;
    dir_t         dir_q;
    logic [10:0]  p0_x, p0_y, p1_x, p1_y;
    logic [10:0]  p0_x_c, p0_y_c, p1_x_c, p1_y_c;

    logic         in0_c, in1_c, hit0_c, hit1_c;
    tile_coord_t  tile0_c, tile1_c;
    logic         hit0, hit1;
    tile_coord_t  tile0, tile1;
    logic         second_pending;
    logic [HW-1:0] hold_cnt;

    // Leading-edge probe points; 11-bit wrap on underflow is caught by the bounds check.
    always_comb begin
        p0_x_c = x_q;
        p0_y_c = y_q;
        p1_x_c = x_q;
        p1_y_c = y_q;
        case (dir_q)
            DIR_UP: begin
                p0_y_c = y_q - 11'd1;
                p1_x_c = x_q + S_LAST;
                p1_y_c = y_q - 11'd1;
            end
            DIR_DOWN: begin
                p0_y_c = y_q + S_FULL;
                p1_x_c = x_q + S_LAST;
                p1_y_c = y_q + S_FULL;
            end
            DIR_LEFT: begin
                p0_x_c = x_q - 11'd1;
                p1_x_c = x_q - 11'd1;
                p1_y_c = y_q + S_LAST;
            end
            default: begin
                p0_x_c = x_q + S_FULL;
                p1_x_c = x_q + S_FULL;
                p1_y_c = y_q + S_LAST;
            end
        endcase
    end

    pixel_to_tile u_probe0 (
        .p_x        (p0_x),
        .p_y        (p0_y),
        .top_left_x (topLeftX),
        .top_left_y (topLeftY),
        .in_field   (in0_c),
        .tile       (tile0_c)
    );

    pixel_to_tile u_probe1 (
        .p_x        (p1_x),
        .p_y        (p1_y),
        .top_left_x (topLeftX),
        .top_left_y (topLeftY),
        .in_field   (in1_c),
        .tile       (tile1_c)
    );

    // The matrix index is only meaningful in-field; the AND masks any out-of-range read.
    always_comb begin
        hit0_c = in0_c && matrix[tile0_c.row][tile0_c.col];
        hit1_c = in1_c && matrix[tile1_c.row][tile1_c.col];
    end

    always_comb begin
        state_next = state;
        kill_next  = 1'b0;
        case (state)
            S_IDLE:   if (startOfFrame && bulletActive) state_next = S_SAMPLE;
            S_SAMPLE: state_next = S_PROBE0;
            S_PROBE0: begin
                if (!in0_c && !in1_c) begin
                    state_next = S_DONE;
                    kill_next  = 1'b1;
                end else if (!hit0_c && !hit1_c) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_PROBE1;
                end
            end
            S_PROBE1: state_next = S_ASSERT;
            S_ASSERT: if (hold_cnt == HW'(HOLD_CYCLES - 1)) state_next = S_RELEASE;
            S_RELEASE: begin
                if (second_pending) begin
                    state_next = S_ASSERT;
                end else begin
                    // RELEASE is only reached after a report, so the pass always ends in a kill.
                    state_next = S_DONE;
                    kill_next  = 1'b1;
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            x_q             <= '0;
            y_q             <= '0;
            dir_q           <= DIR_UP;
            p0_x            <= '0;
            p0_y            <= '0;
            p1_x            <= '0;
            p1_y            <= '0;
            hit0            <= 1'b0;
            hit1            <= 1'b0;
            tile0           <= '0;
            tile1           <= '0;
            second_pending  <= 1'b0;
            hold_cnt        <= '0;
            collision       <= 1'b0;
            brickCollisionX <= '0;
            brickCollisionY <= '0;
            bulletKill      <= 1'b0;
            hitCount        <= '0;
        end else begin
            state      <= state_next;
            // Outputs are registered from the next state so they align with the state they belong to.
            collision  <= (state_next == S_ASSERT);
            bulletKill <= kill_next;

            if (state == S_IDLE && state_next == S_SAMPLE) begin
                x_q   <= bulletX;
                y_q   <= bulletY;
                dir_q <= dir_t'(bulletDir);
            end

            if (state == S_SAMPLE) begin
                p0_x <= p0_x_c;
                p0_y <= p0_y_c;
                p1_x <= p1_x_c;
                p1_y <= p1_y_c;
            end

            // Matrix is sampled here only; later receiver updates cannot change this pass.
            if (state == S_PROBE0) begin
                hit0  <= hit0_c;
                hit1  <= hit1_c;
                tile0 <= tile0_c;
                tile1 <= tile1_c;
            end

            if (state == S_PROBE1) begin
                second_pending  <= hit0 && hit1 && (tile0 != tile1);
                brickCollisionX <= hit0 ? tile0.col : tile1.col;
                brickCollisionY <= hit0 ? tile0.row : tile1.row;
            end

            if (state == S_RELEASE && second_pending) begin
                second_pending  <= 1'b0;
                brickCollisionX <= tile1.col;
                brickCollisionY <= tile1.row;
            end

            if (state != S_ASSERT && state_next == S_ASSERT) begin
                hold_cnt <= '0;
                if (hitCount != 8'hFF) hitCount <= hitCount + 8'd1;
            end else if (state == S_ASSERT) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_brick_hit_reporter.sv
// tb/tb_brick_hit_reporter.sv - directed self-checking bench for brick_hit_reporter
module tb_brick_hit_reporter;

    logic               clk;
    logic               reset;
    logic               startOfFrame;
    logic               bulletActive;
    logic [10:0]        bulletX;
    logic [10:0]        bulletY;
    logic [1:0]         bulletDir;
    logic [10:0]        topLeftX;
    logic [10:0]        topLeftY;
    logic [13:0][16:0]  matrix;
    logic               collision;
    logic [4:0]         brickCollisionX;
    logic [3:0]         brickCollisionY;
    logic               bulletKill;
    logic [7:0]         hitCount;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] col_pat;
    logic [15:0] kill_pat;
    logic [4:0]  x_log  [0:15];
    logic [3:0]  y_log  [0:15];
    logic [7:0]  hc_log [0:15];

    brick_hit_reporter dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .bulletActive    (bulletActive),
        .bulletX         (bulletX),
        .bulletY         (bulletY),
        .bulletDir       (bulletDir),
        .topLeftX        (topLeftX),
        .topLeftY        (topLeftY),
        .matrix          (matrix),
        .collision       (collision),
        .brickCollisionX (brickCollisionX),
        .brickCollisionY (brickCollisionY),
        .bulletKill      (bulletKill),
        .hitCount        (hitCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Cycle 0 carries startOfFrame; cycle c is sampled mid-period after the c-th rising edge.
    // Events requested for cycle c are driven after sampling and take effect at the end of cycle c.
    task automatic run_pass(input int ncyc, input int sof_cyc, input int rst_cyc, input int clr_cyc);
        col_pat  = '0;
        kill_pat = '0;
        @(negedge clk);
        startOfFrame = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            startOfFrame = 1'b0;
            reset        = 1'b0;
            col_pat[c]   = collision;
            kill_pat[c]  = bulletKill;
            x_log[c]     = brickCollisionX;
            y_log[c]     = brickCollisionY;
            hc_log[c]    = hitCount;
            if (c == sof_cyc) startOfFrame = 1'b1;
            if (c == rst_cyc) reset = 1'b1;
            if (c == clr_cyc) matrix = '0;
        end
        startOfFrame = 1'b0;
        reset        = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        startOfFrame = 1'b0;
        bulletActive = 1'b1;
        bulletX      = '0;
        bulletY      = '0;
        bulletDir    = 2'd0;
        topLeftX     = '0;
        topLeftY     = '0;
        matrix       = '0;
        repeat (3) @(negedge clk);
        chk("reset_collision", 32'(collision), 32'd0);
        chk("reset_kill", 32'(bulletKill), 32'd0);
        chk("reset_hitcount", 32'(hitCount), 32'd0);
        chk("reset_coords", 32'({brickCollisionX, brickCollisionY}), 32'd0);
        reset = 1'b0;

        // Up: probes (100,127),(107,127) both in tile col 3 row 3 -> single report.
        bulletX = 11'd100; bulletY = 11'd128; bulletDir = 2'd0;
        matrix = '0; matrix[3][3] = 1'b1;
        run_pass(9, 0, 0, 0);
        chk("up_collision_pattern", 32'(col_pat), 32'h0030);
        chk("up_kill_pattern", 32'(kill_pat), 32'h0080);
        chk("up_x_c4", 32'(x_log[4]), 32'd3);
        chk("up_y_c5", 32'(y_log[5]), 32'd3);
        chk("up_hitcount", 32'(hitCount), 32'd1);

        // Right: probes (96,60),(96,67) -> tiles (3,1) then (3,2); matrix cleared during first ASSERT.
        bulletX = 11'd88; bulletY = 11'd60; bulletDir = 2'd1;
        matrix = '0; matrix[1][3] = 1'b1; matrix[2][3] = 1'b1;
        run_pass(12, 0, 0, 4);
        chk("right_collision_pattern", 32'(col_pat), 32'h01B0);
        chk("right_kill_pattern", 32'(kill_pat), 32'h0400);
        chk("right_first_xy", 32'({x_log[5], y_log[5]}), 32'({5'd3, 4'd1}));
        chk("right_second_xy", 32'({x_log[8], y_log[8]}), 32'({5'd3, 4'd2}));
        chk("right_hitcount", 32'(hitCount), 32'd3);

        // Left at X=0: probe X wraps to 2047, out of field even with a full matrix.
        bulletX = 11'd0; bulletY = 11'd50; bulletDir = 2'd3;
        matrix = '1;
        run_pass(8, 0, 0, 0);
        chk("left_collision_pattern", 32'(col_pat), 32'h0000);
        chk("left_kill_pattern", 32'(kill_pat), 32'h0008);
        chk("left_hitcount", 32'(hitCount), 32'd3);

        // Down into empty tiles: nothing at all.
        bulletX = 11'd100; bulletY = 11'd100; bulletDir = 2'd2;
        matrix = '0;
        run_pass(8, 0, 0, 0);
        chk("down_empty_collision", 32'(col_pat), 32'h0000);
        chk("down_empty_kill", 32'(kill_pat), 32'h0000);

        // Offset field, right boundary: probes (555,8) in col 16, (562,8) past field edge.
        topLeftX = 11'd16; bulletX = 11'd555; bulletY = 11'd0; bulletDir = 2'd2;
        matrix = '0; matrix[0][16] = 1'b1;
        run_pass(9, 0, 0, 0);
        chk("edge_collision_pattern", 32'(col_pat), 32'h0030);
        chk("edge_xy", 32'({x_log[4], y_log[4]}), 32'({5'd16, 4'd0}));
        chk("edge_kill_pattern", 32'(kill_pat), 32'h0080);
        chk("edge_hitcount", 32'(hitCount), 32'd4);
        topLeftX = 11'd0;

        // startOfFrame during ASSERT is ignored.
        bulletX = 11'd100; bulletY = 11'd128; bulletDir = 2'd0;
        matrix = '0; matrix[3][3] = 1'b1;
        run_pass(12, 4, 0, 0);
        chk("sof_in_assert_collision", 32'(col_pat), 32'h0030);
        chk("sof_in_assert_kill", 32'(kill_pat), 32'h0080);
        chk("sof_in_assert_hitcount", 32'(hitCount), 32'd5);

        // Reset in the first ASSERT cycle aborts the pass.
        run_pass(9, 0, 4, 0);
        chk("rst_collision_c4", 32'(col_pat[4]), 32'd1);
        chk("rst_collision_after", 32'(col_pat), 32'h0010);
        chk("rst_hitcount_c5", 32'(hc_log[5]), 32'd0);
        chk("rst_kill_pattern", 32'(kill_pat), 32'h0000);

        // Saturation of hitCount.
        for (int i = 0; i < 254; i++) run_pass(9, 0, 0, 0);
        chk("sat_254", 32'(hitCount), 32'd254);
        run_pass(9, 0, 0, 0);
        chk("sat_255", 32'(hitCount), 32'd255);
        run_pass(9, 0, 0, 0);
        chk("sat_hold_256", 32'(hitCount), 32'd255);
        chk("sat_still_reports", 32'(col_pat), 32'h0030);
        run_pass(9, 0, 0, 0);
        chk("sat_hold_257", 32'(hitCount), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
